// File: rtl/mem_responder.sv
// Bus-side memory responder: one request at a time, programmable wait, then a
// word access to internal RAM or the memory-mapped output register.
module mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] io_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [31:0] rdata_q;
  logic [31:0] io_q;

  logic [31:0] mem [2**ADDR_W];

  logic              commit;
  logic              acc_io;
  logic              acc_ram;
  logic              resp_oor;
  logic [ADDR_W-1:0] acc_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = address;
          rw_d    = rw;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The _d copies equal the live inputs on a zero-wait accept and the latched
  // request otherwise, so one decode serves both paths into RESP.
  always_comb begin
    commit   = (state_d == ST_RESP);
    acc_io   = (addr_d == IO_ADDR);
    acc_ram  = ((addr_d >> ADDR_W) == '0);
    acc_idx  = addr_d[ADDR_W-1:0];
    resp_oor = (addr_q != IO_ADDR) && ((addr_q >> ADDR_W) != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      if (commit) begin
        if (acc_io) begin
          if (rw_d) io_q <= wdata_d;
          else      rdata_q <= io_q;
        end else if (acc_ram) begin
          if (!rw_d) rdata_q <= mem[acc_idx];
        end else if (!rw_d) begin
          rdata_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && commit && rw_d && !acc_io && acc_ram) begin
      mem[acc_idx] <= wdata_d;
    end
  end

  assign ready  = (state_q == ST_RESP);
  assign err    = ready && resp_oor;
  assign rdata  = rdata_q;
  assign io_out = io_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level schedule model checked every
// cycle, plus directed transactions with hand-computed expectations.
module tb_mem_responder;

  localparam int unsigned W     = 1;
  localparam int unsigned AW    = 10;
  localparam logic [31:0] IOA   = 32'hFFFF_FFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        rw    = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata   = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] io_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_responder #(
    .ADDR_W(AW),
    .WAIT_CYCLES(W),
    .IO_ADDR(IOA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .rw(rw),
    .address(address),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .err(err),
    .io_out(io_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a request accepted at edge k completes at edge k+W; the edge after
  // the ready cycle can never accept.
  bit          m_init = 0;
  bit          m_busy = 0;
  bit          m_resp = 0;
  bit          m_err  = 0;
  int          m_due  = 0;
  bit          m_w;
  logic [31:0] m_a, m_d;
  logic [31:0] m_rdata = '0;
  bit          m_rd_known = 0;
  logic [31:0] m_io = '0;
  logic [31:0] mm [1024];
  bit          mk [1024];

  always @(posedge clock) begin
    bit leaving;
    cyc = cyc + 1;
    if (!reset) begin
      m_init = 1; m_busy = 0; m_resp = 0; m_err = 0;
      m_rdata = '0; m_rd_known = 1; m_io = '0;
    end else if (m_init) begin
      leaving = m_resp;
      m_resp = 0;
      m_err  = 0;
      if (!leaving && !m_busy && req) begin
        m_busy = 1; m_due = cyc + int'(W);
        m_w = rw; m_a = address; m_d = wdata;
      end
      if (m_busy && cyc == m_due) begin
        m_busy = 0;
        m_resp = 1;
        if (m_a == IOA) begin
          if (m_w) m_io = m_d;
          else begin m_rdata = m_io; m_rd_known = 1; end
        end else if (m_a < 32'd1024) begin
          if (m_w) begin mm[m_a[9:0]] = m_d; mk[m_a[9:0]] = 1; end
          else begin m_rdata = mm[m_a[9:0]]; m_rd_known = mk[m_a[9:0]]; end
        end else begin
          m_err = 1;
          if (!m_w) begin m_rdata = '0; m_rd_known = 1; end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      chk("model ready", 32'(ready), 32'(m_resp));
      chk("model err", 32'(err), 32'(m_err));
      chk("model io_out", io_out, m_io);
      if (m_rd_known) chk("model rdata", rdata, m_rdata);
    end
  end

  // Issue one request; during the wait, drive conflicting inputs that must be ignored.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output logic [31:0] io,
                      output int lat);
    int start;
    bit seen;
    req = 1; rw = w; address = a; wdata = d;
    @(posedge clock); #1;
    start = cyc;
    rw = ~w; address = 32'h3; wdata = 32'hBADBAD00;
    seen = 0; lat = 0; rd = '0; e = 0; io = '0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (ready) begin
        seen = 1;
        lat  = cyc - start + 1;
        rd = rdata; e = err; io = io_out;
        req = 0; rw = 0;
      end
    end
    if (!seen) chk("ready timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] rd, io;
    logic        e;
    int          lat, n, last, cnt;
    logic [31:0] b2b_exp [3];

    b2b_exp[0] = 32'h1111_0001;
    b2b_exp[1] = 32'h2222_0002;
    b2b_exp[2] = 32'h3333_0003;

    // Reset then idle
    reset = 0; req = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle ready", 32'(ready), 32'd0);
      chk("idle err", 32'(err), 32'd0);
      chk("idle rdata", rdata, 32'd0);
      chk("idle io_out", io_out, 32'd0);
    end
    @(posedge clock); #1;

    // RAM write/read
    xact(1'b1, 32'd5, 32'hDEAD_BEEF, rd, e, io, lat);
    chk("wr5 latency", 32'(lat), 32'd2);
    chk("wr5 err", 32'(e), 32'd0);
    chk("wr5 rdata unchanged", rd, 32'd0);
    xact(1'b0, 32'd5, 32'h0, rd, e, io, lat);
    chk("rd5 data", rd, 32'hDEAD_BEEF);
    chk("rd5 err", 32'(e), 32'd0);
    chk("rd5 latency", 32'(lat), 32'd2);

    // IO register
    xact(1'b1, IOA, 32'h0000_00A5, rd, e, io, lat);
    chk("io wr io_out", io, 32'h0000_00A5);
    chk("io wr err", 32'(e), 32'd0);
    xact(1'b0, IOA, 32'h0, rd, e, io, lat);
    chk("io rd data", rd, 32'h0000_00A5);

    // Out of range
    xact(1'b1, 32'd0, 32'hCAFE_0000, rd, e, io, lat);
    xact(1'b1, 32'h0000_0400, 32'h1234_5678, rd, e, io, lat);
    chk("oor wr err", 32'(e), 32'd1);
    xact(1'b0, 32'd0, 32'h0, rd, e, io, lat);
    chk("rd0 unchanged", rd, 32'hCAFE_0000);
    chk("rd0 err", 32'(e), 32'd0);
    xact(1'b0, 32'h0000_0400, 32'h0, rd, e, io, lat);
    chk("oor rd data", rd, 32'd0);
    chk("oor rd err", 32'(e), 32'd1);

    // Back-to-back reads with req held high
    xact(1'b1, 32'd1, b2b_exp[0], rd, e, io, lat);
    xact(1'b1, 32'd2, b2b_exp[1], rd, e, io, lat);
    xact(1'b1, 32'd3, b2b_exp[2], rd, e, io, lat);
    xact(1'b1, 32'd7, 32'h7777_0007, rd, e, io, lat);
    req = 1; rw = 0; address = 32'd1; wdata = 32'hFFFF_0000;
    n = 0; last = 0;
    for (int t = 0; t < 30 && n < 3; t++) begin
      @(negedge clock);
      if (ready) begin
        chk("b2b data", rdata, b2b_exp[n]);
        if (n > 0) chk("b2b spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
        address = 32'(n + 1);
        if (n == 3) req = 0;
      end
    end
    chk("b2b count", 32'(n), 32'd3);
    req = 0;
    @(posedge clock); #1;

    // Reset during WAIT aborts the write
    req = 1; rw = 1; address = 32'd7; wdata = 32'h1111_1111;
    @(posedge clock); #1;
    req = 0; rw = 0;
    reset = 0;
    @(posedge clock); #1;
    reset = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ready) cnt++;
      if (i == 0) begin
        chk("mid-rst rdata", rdata, 32'd0);
        chk("mid-rst io_out", io_out, 32'd0);
      end
    end
    chk("mid-rst no ready", 32'(cnt), 32'd0);
    @(posedge clock); #1;
    xact(1'b0, 32'd7, 32'h0, rd, e, io, lat);
    chk("rd7 old value", rd, 32'h7777_0007);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got %0d expected done", cyc);
    $fatal(1, "timeout");
  end

endmodule
